// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: packed-BCD to binary, one bit per clock.
// Reverse double-dabble with start/busy/done handshake.
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BIN_W-1:0]      bin_out
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [BW-1:0]    bcd_r;
  logic [BW-1:0]    bcd_sh;
  logic [BW-1:0]    bcd_fx;
  logic [BIN_W-1:0] bin_r;
  logic [BIN_W-1:0] bin_sh;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             bad;
  logic             last;

  assign accept = start && (state != SHIFT);
  assign last   = (cnt == CW'(BIN_W - 1));
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);

  // flag any nibble of the incoming word above 9
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad = 1'b1;
    end
  end

  // one shift step: move right, then pull 3 from digits >= 8
  always_comb begin
    bcd_sh = {1'b0, bcd_r[BW-1:1]};
    bin_sh = {bcd_r[0], bin_r[BIN_W-1:1]};
    bcd_fx = bcd_sh;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_sh[4*i +: 4] >= 4'd8) begin
        bcd_fx[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = bad ? DONE : SHIFT;
      end
      SHIFT: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        if (accept) state_nx = bad ? DONE : SHIFT;
        else        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // working registers and result outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bcd_r   <= '0;
      bin_r   <= '0;
      cnt     <= '0;
      err     <= 1'b0;
      bin_out <= '0;
    end else if (accept) begin
      bcd_r <= bcd_in;
      bin_r <= '0;
      cnt   <= '0;
      err   <= bad;
      if (bad) bin_out <= '0;
    end else if (state == SHIFT) begin
      bcd_r <= bcd_fx;
      bin_r <= bin_sh;
      cnt   <= cnt + 1'b1;
      if (last) bin_out <= bin_sh;
    end
  end

endmodule
